// File: rtl/composite_line_sequencer_pkg.sv
// composite_pkg: shared types and default timing for the composite line
// sequencer. Defaults target 4x fsc NTSC sampling (910 samples per line).
package composite_pkg;

  typedef enum logic [2:0] {
    FLUSH,
    SEARCH,
    PORCH,
    ACTIVE,
    WAIT
  } line_state_e;

  localparam int LINE_SAMPLES     = 910;
  localparam int LINE_COUNT_W     = 10;

  localparam int DEF_DATA_WIDTH   = 12;
  localparam int DEF_WINDOW_SIZE  = 32;
  localparam int DEF_SYNC_THRESH  = -1024;
  localparam int DEF_SYNC_MIN     = 48;
  localparam int DEF_BURST_START  = 28;
  localparam int DEF_BURST_LEN    = 32;
  localparam int DEF_ACTIVE_START = 96;
  localparam int DEF_ACTIVE_LEN   = 752;
  localparam int DEF_LINE_TIMEOUT = 1023;
  localparam int DEF_OUT_DELAY    = 3;

endpackage

// File: rtl/composite_line_sequencer_if.sv
// composite_line_if: bundles the raw ADC sample input with the separator
// feed (sep_data/sep_rst) and the line-timing outputs.
//   master : sample source side, drives data_in, observes everything else
//   slave  : the sequencer, consumes data_in, drives all other signals
interface composite_line_if #(
  parameter int DATA_WIDTH = composite_pkg::DEF_DATA_WIDTH
) ();
  import composite_pkg::*;

  logic signed [DATA_WIDTH-1:0]  data_in;
  logic signed [DATA_WIDTH-1:0]  sep_data;
  logic                          sep_rst;
  logic                          line_start;
  logic                          burst_gate;
  logic                          active_valid;
  logic [LINE_COUNT_W-1:0]       line_count;
  logic                          sync_lock;
  logic                          sync_lost;

  modport master (
    output data_in,
    input  sep_data, sep_rst, line_start, burst_gate, active_valid,
           line_count, sync_lock, sync_lost
  );

  modport slave (
    input  data_in,
    output sep_data, sep_rst, line_start, burst_gate, active_valid,
           line_count, sync_lock, sync_lost
  );
endinterface

// File: rtl/composite_line_sequencer_sync_tip_detector.sv
// sync_tip_detector: counts consecutive samples below SYNC_THRESH and
// fires sync_det (combinational) on the sample that completes a run of
// SYNC_MIN. The run saturates, so one long tip yields exactly one pulse.
//   clk, rst  : sample clock, synchronous active-high reset
//   sample    : signed raw composite sample
//   sync_det  : high while the current sample is the SYNC_MIN-th low one
module sync_tip_detector #(
  parameter int DATA_WIDTH  = 12,
  parameter int SYNC_THRESH = -1024,
  parameter int SYNC_MIN    = 48
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [DATA_WIDTH-1:0] sample,
  output logic                         sync_det
);
  localparam int RW = $clog2(SYNC_MIN + 1);
  localparam logic [RW-1:0] RUN_MAX = RW'(SYNC_MIN);
  localparam logic [RW-1:0] RUN_ARM = RW'(SYNC_MIN - 1);
  localparam logic signed [DATA_WIDTH-1:0] THRESH = DATA_WIDTH'(SYNC_THRESH);

  logic          below;
  logic [RW-1:0] run_q, run_d;

  always_comb begin
    below    = (sample < THRESH);
    run_d    = '0;
    sync_det = 1'b0;
    if (below) begin
      run_d    = (run_q == RUN_MAX) ? run_q : run_q + RW'(1);
      sync_det = (run_q == RUN_ARM);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) run_q <= '0;
    else     run_q <= run_d;
  end
endmodule

// File: rtl/composite_line_sequencer.sv
// composite_line_sequencer: line-timing controller in front of the Y/C
// separator. Detects sync tips, walks each line through porch, burst and
// active video, owns the separator reset/input mux (flushing its window
// with zeros) and emits burst/active gates aligned to separator outputs.
//   clk, rst : sample clock, synchronous active-high reset
//   bus      : composite_line_if slave (data_in in; sep_data, sep_rst,
//              line_start, burst_gate, active_valid, line_count,
//              sync_lock, sync_lost out)
module composite_line_sequencer
  import composite_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int WINDOW_SIZE  = DEF_WINDOW_SIZE,
  parameter int SYNC_THRESH  = DEF_SYNC_THRESH,
  parameter int SYNC_MIN     = DEF_SYNC_MIN,
  parameter int BURST_START  = DEF_BURST_START,
  parameter int BURST_LEN    = DEF_BURST_LEN,
  parameter int ACTIVE_START = DEF_ACTIVE_START,
  parameter int ACTIVE_LEN   = DEF_ACTIVE_LEN,
  parameter int LINE_TIMEOUT = DEF_LINE_TIMEOUT,
  parameter int OUT_DELAY    = DEF_OUT_DELAY
) (
  input  logic            clk,
  input  logic            rst,
  composite_line_if.slave bus
);
  if (BURST_START + BURST_LEN > ACTIVE_START) begin : g_chk_burst
    $error("burst window must end before the active window starts");
  end
  if (ACTIVE_START + ACTIVE_LEN >= LINE_TIMEOUT) begin : g_chk_active
    $error("active window must end before the line timeout");
  end

  localparam int PW = $clog2(LINE_TIMEOUT + 1);
  localparam int FW = $clog2(WINDOW_SIZE + 1);
  typedef logic [PW-1:0] pos_t;

  localparam pos_t POS_BURST_LO   = pos_t'(BURST_START);
  localparam pos_t POS_BURST_HI   = pos_t'(BURST_START + BURST_LEN);
  localparam pos_t POS_PORCH_END  = pos_t'(ACTIVE_START - 1);
  localparam pos_t POS_ACTIVE_END = pos_t'(ACTIVE_START + ACTIVE_LEN - 1);
  localparam pos_t POS_TIMEOUT    = pos_t'(LINE_TIMEOUT);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(WINDOW_SIZE - 1);

  function automatic pos_t pos_sat_inc(input pos_t p);
    return (p == POS_TIMEOUT) ? p : p + pos_t'(1);
  endfunction

  line_state_e                  state_q, state_d;
  logic [FW-1:0]                flush_cnt_q, flush_cnt_d;
  pos_t                         pos_q, pos_d;
  logic [LINE_COUNT_W-1:0]      line_count_q, line_count_d;
  logic                         sync_lock_q, sync_lock_d;
  logic                         sync_lost_q, sync_lost_d;
  logic                         line_start_q, line_start_d;
  logic                         sep_rst_q, sep_rst_d;
  logic signed [DATA_WIDTH-1:0] sep_data_q, sep_data_d;
  logic [OUT_DELAY-1:0]         burst_dly_q, burst_dly_d;
  logic [OUT_DELAY-1:0]         active_dly_q, active_dly_d;
  logic                         sync_det, accept, timeout;

  sync_tip_detector #(
    .DATA_WIDTH  (DATA_WIDTH),
    .SYNC_THRESH (SYNC_THRESH),
    .SYNC_MIN    (SYNC_MIN)
  ) u_tip (
    .clk      (clk),
    .rst      (rst),
    .sample   (bus.data_in),
    .sync_det (sync_det)
  );

  always_comb begin
    state_d      = state_q;
    flush_cnt_d  = '0;
    pos_d        = pos_sat_inc(pos_q);
    line_count_d = line_count_q;
    sync_lock_d  = sync_lock_q;
    accept       = 1'b0;
    timeout      = 1'b0;

    unique case (state_q)
      FLUSH: begin
        flush_cnt_d = flush_cnt_q + FW'(1);
        if (flush_cnt_q == FLUSH_LAST) state_d = SEARCH;
      end
      SEARCH: begin
        // first sync after a flush starts a line but does not count it
        if (sync_det) begin
          accept  = 1'b1;
          state_d = PORCH;
        end
      end
      PORCH:  if (pos_q == POS_PORCH_END)  state_d = ACTIVE;
      ACTIVE: if (pos_q == POS_ACTIVE_END) state_d = WAIT;
      WAIT: begin
        // a sync landing on the timeout sample still wins
        if (sync_det) begin
          accept       = 1'b1;
          state_d      = PORCH;
          sync_lock_d  = 1'b1;
          line_count_d = line_count_q + LINE_COUNT_W'(1);
        end else if (pos_q == POS_TIMEOUT) begin
          timeout      = 1'b1;
          state_d      = FLUSH;
          sync_lock_d  = 1'b0;
          line_count_d = '0;
        end
      end
      default: state_d = FLUSH;
    endcase

    if (accept) pos_d = '0;

    line_start_d = accept;
    sync_lost_d  = timeout;
    sep_rst_d    = (state_d == FLUSH);
    sep_data_d   = (state_d == FLUSH) ? '0 : bus.data_in;

    // gates pass through OUT_DELAY flops to line up with separator output
    burst_dly_d     = burst_dly_q << 1;
    burst_dly_d[0]  = (state_q == PORCH) && (pos_q >= POS_BURST_LO) &&
                      (pos_q < POS_BURST_HI);
    active_dly_d    = active_dly_q << 1;
    active_dly_d[0] = (state_q == ACTIVE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FLUSH;
      flush_cnt_q  <= '0;
      pos_q        <= '0;
      line_count_q <= '0;
      sync_lock_q  <= 1'b0;
      sync_lost_q  <= 1'b0;
      line_start_q <= 1'b0;
      sep_rst_q    <= 1'b1;
      sep_data_q   <= '0;
      burst_dly_q  <= '0;
      active_dly_q <= '0;
    end else begin
      state_q      <= state_d;
      flush_cnt_q  <= flush_cnt_d;
      pos_q        <= pos_d;
      line_count_q <= line_count_d;
      sync_lock_q  <= sync_lock_d;
      sync_lost_q  <= sync_lost_d;
      line_start_q <= line_start_d;
      sep_rst_q    <= sep_rst_d;
      sep_data_q   <= sep_data_d;
      burst_dly_q  <= burst_dly_d;
      active_dly_q <= active_dly_d;
    end
  end

  assign bus.sep_data     = sep_data_q;
  assign bus.sep_rst      = sep_rst_q;
  assign bus.line_start   = line_start_q;
  assign bus.burst_gate   = burst_dly_q[OUT_DELAY-1];
  assign bus.active_valid = active_dly_q[OUT_DELAY-1];
  assign bus.line_count   = line_count_q;
  assign bus.sync_lock    = sync_lock_q;
  assign bus.sync_lost    = sync_lost_q;
endmodule

// File: tb/tb_composite_line_sequencer.sv
// Bench for composite_line_sequencer: directed sync/line stimulus, a
// time-based reference model checked every cycle, plus literal checks.
module tb_composite_line_sequencer;
  localparam int TH = -1024;
  localparam int SMIN = 48;
  localparam int BS = 28, BE = 60, AS = 96, AE = 848;
  localparam int TMO = 1023, FLUSH_N = 32, DLY = 3;

  logic clk;
  logic rst;
  composite_line_if #(.DATA_WIDTH(12)) bus ();

  composite_line_sequencer dut (.clk(clk), .rst(rst), .bus(bus));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, want %0d", name, cyc, act, exp);
    end
  endtask

  // Reference model: tracks time since the last accepted sync rather than
  // a state machine; windows and eligibility are phase ranges.
  int m_lowrun = 0, m_phase = 0, m_count = 0, m_flush_end = 0, m_last_rst = 0;
  bit m_inline = 0, m_lock = 0;
  bit hist_b[8], hist_a[8];
  int e_sepdata = 0;
  bit e_seprst = 1, e_ls = 0, e_lost = 0, e_burst = 0, e_active = 0;

  task automatic model_step();
    int n, din;
    bit det, searching, waiting, acc, tmo;
    cyc++;
    n = cyc;
    din = int'(bus.data_in);
    if (rst) begin
      m_lowrun = 0; m_inline = 0; m_lock = 0; m_count = 0;
      m_flush_end = n + FLUSH_N; m_last_rst = n;
      hist_b[n % 8] = 0; hist_a[n % 8] = 0;
      e_seprst = 1; e_sepdata = 0; e_ls = 0; e_lost = 0;
      e_burst = 0; e_active = 0;
      return;
    end
    m_lowrun = (din < TH) ? m_lowrun + 1 : 0;
    det = (m_lowrun == SMIN);
    searching = !m_inline && (n - 1 >= m_flush_end);
    waiting = m_inline && (m_phase >= AE);
    acc = det && (searching || waiting);
    tmo = !acc && waiting && (m_phase == TMO);
    if (acc) begin
      if (waiting) begin m_lock = 1; m_count = (m_count + 1) % 1024; end
      m_inline = 1; m_phase = 0;
    end else if (tmo) begin
      m_inline = 0; m_lock = 0; m_count = 0; m_flush_end = n + FLUSH_N;
    end else if (m_inline) begin
      m_phase++;
    end
    hist_b[n % 8] = m_inline && m_phase >= BS && m_phase < BE;
    hist_a[n % 8] = m_inline && m_phase >= AS && m_phase < AE;
    e_burst  = (n - DLY >= m_last_rst) ? hist_b[(n - DLY) % 8] : 1'b0;
    e_active = (n - DLY >= m_last_rst) ? hist_a[(n - DLY) % 8] : 1'b0;
    e_seprst = (n < m_flush_end);
    e_sepdata = e_seprst ? 0 : din;
    e_ls = acc;
    e_lost = tmo;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // per-cycle compare plus gate measurements relative to line_start
  int ls_cyc = 0, burst_rise = -1, burst_cnt = 0, act_rise = -1, act_cnt = 0;
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("sep_rst", bus.sep_rst, e_seprst);
      chk("sep_data", bus.sep_data, e_sepdata);
      chk("line_start", bus.line_start, e_ls);
      chk("burst_gate", bus.burst_gate, e_burst);
      chk("active_valid", bus.active_valid, e_active);
      chk("line_count", bus.line_count, m_count);
      chk("sync_lock", bus.sync_lock, m_lock);
      chk("sync_lost", bus.sync_lost, e_lost);
      if (bus.line_start === 1'b1) begin
        ls_cyc = cyc; burst_rise = -1; burst_cnt = 0; act_rise = -1; act_cnt = 0;
      end
      if (bus.burst_gate === 1'b1) begin
        if (burst_rise < 0) burst_rise = cyc;
        burst_cnt++;
      end
      if (bus.active_valid === 1'b1) begin
        if (act_rise < 0) act_rise = cyc;
        act_cnt++;
      end
    end
  end

  int tip_ls_cyc = 0;

  task automatic hold(input int len, input int val);
    for (int i = 0; i < len; i++) begin
      bus.data_in = 12'(val);
      @(negedge clk);
    end
  endtask

  task automatic tip(input int len, input bit exp_ls, input int exp_cnt,
                     input bit exp_lock);
    for (int i = 0; i < len; i++) begin
      bus.data_in = 12'(-1500);
      @(negedge clk);
      chk("tip_line_start", bus.line_start, (i == SMIN - 1) && exp_ls);
      if (i == SMIN - 1 && exp_ls) begin
        tip_ls_cyc = cyc;
        chk("tip_line_count", bus.line_count, exp_cnt);
        chk("tip_sync_lock", bus.sync_lock, exp_lock);
      end
    end
  endtask

  task automatic flush_check();
    for (int k = 0; k < 36; k++) begin
      bus.data_in = 12'(100 + k);
      @(negedge clk);
      chk("flush_sep_rst", bus.sep_rst, k < 31);
      chk("flush_sep_data", bus.sep_data, (k >= 31) ? 100 + k : 0);
    end
  endtask

  task automatic check_gates(input string tag);
    chk({tag, "_burst_delay"}, burst_rise - ls_cyc, 31);
    chk({tag, "_burst_len"}, burst_cnt, 32);
    chk({tag, "_active_delay"}, act_rise - ls_cyc, 99);
    chk({tag, "_active_len"}, act_cnt, 752);
  endtask

  initial begin
    int w;
    rst = 1'b1;
    bus.data_in = '0;
    repeat (3) @(negedge clk);
    chk("reset_sep_rst", bus.sep_rst, 1);
    chk("reset_line_count", bus.line_count, 0);
    chk("reset_active", bus.active_valid, 0);
    rst = 1'b0;
    flush_check();

    // single line from SEARCH
    tip(64, 1, 0, 0);
    hold(846, 200);
    check_gates("line1");

    // periodic lines: lock on the second accepted sync
    tip(64, 1, 1, 1);
    hold(846, 200);
    tip(64, 1, 2, 1);
    hold(846, 200);

    // a full tip inside ACTIVE is ignored and gate timing is kept
    tip(64, 1, 3, 1);
    hold(200, 200);
    tip(64, 0, 0, 1);
    hold(582, 200);
    check_gates("line4");

    // 47-sample tip never qualifies
    tip(47, 0, 0, 1);
    hold(20, 200);
    tip(64, 1, 4, 1);

    // sync on the timeout sample wins
    hold(960, 200);
    tip(64, 1, 5, 1);
    chk("boundary_no_lost", bus.sync_lost, 0);

    // stop syncing: timeout 1024 cycles after the last line_start
    w = 0;
    while (bus.sync_lost !== 1'b1 && w < 1200) begin
      bus.data_in = 12'(200);
      @(negedge clk);
      w++;
    end
    chk("lost_seen", bus.sync_lost, 1);
    chk("lost_delay", cyc - tip_ls_cyc, 1024);
    chk("lost_lock", bus.sync_lock, 0);
    chk("lost_count", bus.line_count, 0);
    chk("lost_sep_rst", bus.sep_rst, 1);
    flush_check();

    // relock, then reset in the middle of ACTIVE
    tip(64, 1, 0, 0);
    hold(846, 200);
    tip(64, 1, 1, 1);
    hold(200, 200);
    chk("pre_rst_active", bus.active_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_active", bus.active_valid, 0);
    chk("rst_sep_rst", bus.sep_rst, 1);
    chk("rst_sep_data", bus.sep_data, 0);
    chk("rst_lock", bus.sync_lock, 0);
    chk("rst_count", bus.line_count, 0);
    rst = 1'b0;
    flush_check();
    hold(5, 200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end
endmodule
